pfc_pause_ctrl: RTL and testbench
=================================

Name: pfc_pause_ctrl

Overview:
Per-priority (802.1Qbb-style) flow-control generator; the multi-class successor of the single-threshold 802.3x pause logic in the MAC wrapper. Tracks NUM_CH already-synchronised RX FIFO occupancy levels against programmable hysteresis thresholds and issues XOFF/XON pause requests to the MAC transmit side through a req/ack handshake. Re-sends XOFF before the link partner's pause expires. Sits in the tx_mac_aclk domain between the RX client FIFOs' status outputs and the MAC pause interface.

Parameters:
NUM_CH, 8, number of priority classes (1..8; NUM_CH=1 gives legacy 802.3x behaviour)
LEVEL_W, 4, width of each FIFO level input
TIMER_W, 24, width of refresh timer and refresh period config
CNT_W, 32, width of the sent-frame counter

Ports:
tx_mac_aclk  in  1  sole clock
tx_mac_resetn  in  1  reset, asynchronous assert, active-low
cfg_enable  in  1  global flow-control enable
cfg_high  in  LEVEL_W  XOFF threshold (level > cfg_high)
cfg_low  in  LEVEL_W  XON threshold (level <= cfg_low); requires cfg_low < cfg_high
cfg_quanta  in  16  pause time sent with XOFF classes
cfg_refresh  in  TIMER_W  XOFF refresh period, cycles; 0 disables refresh
fifo_level  in  NUM_CH*LEVEL_W  per-class occupancy, class i at [i*LEVEL_W +: LEVEL_W]
pause_req  out  1  request to MAC; held until ack
pause_ack  in  1  MAC accepted request (single-cycle pulse)
pause_class_en  out  NUM_CH  classes carried in this frame
pause_class_xoff  out  NUM_CH  1 = XOFF (time cfg_quanta), 0 = XON (time 0)
pause_quanta  out  16  quanta latched at launch
xoff_state  out  NUM_CH  current per-class state
frames_sent  out  CNT_W  count of acknowledged requests, wraps

Behaviour:
- Reset: all outputs 0; all classes XON; pending 0; timer 0; sender IDLE.
- Per-class FSM, evaluated every cycle, cfg_enable=1:
  - XON -> XOFF when level > cfg_high; set pending[i].
  - XOFF -> XON when level <= cfg_low; set pending[i].
  - Otherwise hold. Levels between the thresholds never cause a transition.
- cfg_enable=0: every XOFF class goes to XON and sets pending[i], so a release frame is still sent. No XON->XOFF transitions occur.
- Refresh timer:
  - Loads cfg_refresh on every launch that carries at least one XOFF bit.
  - Decrements while any class is XOFF and the sender is IDLE.
  - On reaching 0 with cfg_refresh != 0: sets pending for all XOFF classes and reloads.
  - Forced to 0 when no class is XOFF.
- Sender FSM:
  - IDLE: if pending != 0, launch next cycle:
    - pause_class_en <= pending
    - pause_class_xoff <= xoff_state
    - pause_quanta <= cfg_quanta
    - pending cleared for launched bits
    - pause_req <= 1; go to WAIT. Latency from threshold crossing to pause_req is 2 cycles.
  - WAIT: outputs frozen. pause_ack -> pause_req <= 0, frames_sent += 1, back to IDLE. Earliest next launch is the cycle after return to IDLE.
  - Transitions during WAIT: set pending only; they are carried in the next frame.
  - A class that toggles twice during WAIT is sent with its current state. A class whose state returns to the state last sent still sends one frame; this is harmless.
  - pause_ack while IDLE: ignored.
- Simultaneous launch-clear and new transition on the same class: the new set wins; pending stays 1.
- Asynchronous reset mid-WAIT: pause_req drops immediately and pending is lost. The MAC must tolerate an abandoned request.
- NUM_CH=1: the output reduces to 802.3x; the MAC sends quanta if xoff, else 0.

Test Plan:
- High=8, low=4, class 2 level 0->9 -> pause_req 2 cycles later; class_en=0x04, class_xoff=0x04, quanta=0xFFFF. After ack, frames_sent=1.
- Class 2 level 9->6 -> no request. 6->4 -> request with class_en=0x04, class_xoff=0x00.
- Classes 0 and 5 cross high while in WAIT (ack delayed 20 cycles) -> next frame class_en=0x21, class_xoff=0x21.
- cfg_refresh=100, class 3 held XOFF, ack immediate -> XOFF frames for class 3 every ~100 cycles. Level drops to 0 -> one XON frame, then no further frames.
- Class 1 XOFF, then cfg_enable 1->0 -> XON frame with class_en=0x02, class_xoff=0; xoff_state=0.
- Reset asserted during WAIT -> pause_req=0 that cycle; all outputs 0; after release with levels below low, no request.

Source files
------------

// File: rtl/pfc_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pfc_pause_ctrl
// Brief    : Per-priority XOFF/XON pause generator with refresh and MAC req/ack.
// Revision : 1.0
// ============================================================================
module pfc_pause_ctrl #(
   parameter int NUM_CH  = 8,
   parameter int LEVEL_W = 4,
   parameter int TIMER_W = 24,
   parameter int CNT_W   = 32
) (
   input  logic                        tx_mac_aclk,
   input  logic                        tx_mac_resetn,
   input  logic                        cfg_enable,
   input  logic [LEVEL_W-1:0]          cfg_high,
   input  logic [LEVEL_W-1:0]          cfg_low,
   input  logic [15:0]                 cfg_quanta,
   input  logic [TIMER_W-1:0]          cfg_refresh,
   input  logic [NUM_CH*LEVEL_W-1:0]   fifo_level,
   output logic                        pause_req,
   input  logic                        pause_ack,
   output logic [NUM_CH-1:0]           pause_class_en,
   output logic [NUM_CH-1:0]           pause_class_xoff,
   output logic [15:0]                 pause_quanta,
   output logic [NUM_CH-1:0]           xoff_state,
   output logic [CNT_W-1:0]            frames_sent
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } send_state_t;

   send_state_t          r_send_state;
   logic [NUM_CH-1:0]    r_xoff;
   logic [NUM_CH-1:0]    r_pending;
   logic [NUM_CH-1:0]    r_class_en;
   logic [NUM_CH-1:0]    r_class_xoff;
   logic [15:0]          r_quanta;
   logic                 r_req;
   logic [CNT_W-1:0]     r_frames;
   logic [TIMER_W-1:0]   r_timer;

   logic [NUM_CH-1:0]    w_xoff_next;
   logic [NUM_CH-1:0]    w_toggle;
   logic [NUM_CH-1:0]    w_launch_mask;
   logic [NUM_CH-1:0]    w_refresh_mask;
   logic [NUM_CH-1:0]    w_pending_next;
   logic                 w_idle;
   logic                 w_launch;
   logic                 w_any_xoff;
   logic                 w_refresh_fire;

   // Thresholds are exclusive of each other (low < high), so the order of
   // the two compares only matters for misconfiguration.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_class
         logic [LEVEL_W-1:0] w_level;
         assign w_level = fifo_level[gi*LEVEL_W +: LEVEL_W];
         assign w_xoff_next[gi] = !cfg_enable          ? 1'b0 :
                                  (w_level >  cfg_high) ? 1'b1 :
                                  (w_level <= cfg_low)  ? 1'b0 :
                                  r_xoff[gi];
      end
   endgenerate

   assign w_toggle       = w_xoff_next ^ r_xoff;
   assign w_idle         = (r_send_state == S_IDLE);
   assign w_launch       = w_idle && (r_pending != '0);
   assign w_launch_mask  = w_launch ? r_pending : '0;
   assign w_any_xoff     = |r_xoff;
   assign w_refresh_fire = w_any_xoff && w_idle && !w_launch &&
                           (r_timer == '0) && (cfg_refresh != '0);
   assign w_refresh_mask = w_refresh_fire ? r_xoff : '0;
   // A new transition on a class being launched keeps its pending bit set.
   assign w_pending_next = (r_pending & ~w_launch_mask) | w_toggle | w_refresh_mask;

   always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
      if (!tx_mac_resetn) begin
         r_send_state <= S_IDLE;
         r_xoff       <= '0;
         r_pending    <= '0;
         r_class_en   <= '0;
         r_class_xoff <= '0;
         r_quanta     <= '0;
         r_req        <= 1'b0;
         r_frames     <= '0;
         r_timer      <= '0;
      end else begin
         r_xoff    <= w_xoff_next;
         r_pending <= w_pending_next;

         if (!w_any_xoff) begin
            r_timer <= '0;
         end else if (w_launch && ((r_pending & r_xoff) != '0)) begin
            r_timer <= cfg_refresh;
         end else if (w_refresh_fire) begin
            r_timer <= cfg_refresh;
         end else if (w_idle && (r_timer != '0)) begin
            r_timer <= r_timer - TIMER_W'(1);
         end

         case (r_send_state)
            S_IDLE: begin
               if (w_launch) begin
                  r_class_en   <= r_pending;
                  r_class_xoff <= r_xoff;
                  r_quanta     <= cfg_quanta;
                  r_req        <= 1'b1;
                  r_send_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (pause_ack) begin
                  r_req        <= 1'b0;
                  r_frames     <= r_frames + CNT_W'(1);
                  r_send_state <= S_IDLE;
               end
            end
            default: r_send_state <= S_IDLE;
         endcase
      end
   end

   assign pause_req        = r_req;
   assign pause_class_en   = r_class_en;
   assign pause_class_xoff = r_class_xoff;
   assign pause_quanta     = r_quanta;
   assign xoff_state       = r_xoff;
   assign frames_sent      = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_pfc_pause_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pfc_pause_ctrl
// Brief    : Directed self-checking bench for pfc_pause_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pfc_pause_ctrl;

   localparam int NUM_CH  = 8;
   localparam int LEVEL_W = 4;
   localparam int TIMER_W = 24;
   localparam int CNT_W   = 32;

   logic                       tx_mac_aclk = 1'b0;
   logic                       tx_mac_resetn;
   logic                       cfg_enable;
   logic [LEVEL_W-1:0]         cfg_high;
   logic [LEVEL_W-1:0]         cfg_low;
   logic [15:0]                cfg_quanta;
   logic [TIMER_W-1:0]         cfg_refresh;
   logic [NUM_CH*LEVEL_W-1:0]  fifo_level;
   logic                       pause_req;
   logic                       pause_ack;
   logic [NUM_CH-1:0]          pause_class_en;
   logic [NUM_CH-1:0]          pause_class_xoff;
   logic [15:0]                pause_quanta;
   logic [NUM_CH-1:0]          xoff_state;
   logic [CNT_W-1:0]           frames_sent;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   int exp_frames = 0;
   int extra;

   pfc_pause_ctrl #(
      .NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W), .TIMER_W(TIMER_W), .CNT_W(CNT_W)
   ) dut (
      .tx_mac_aclk      (tx_mac_aclk),
      .tx_mac_resetn    (tx_mac_resetn),
      .cfg_enable       (cfg_enable),
      .cfg_high         (cfg_high),
      .cfg_low          (cfg_low),
      .cfg_quanta       (cfg_quanta),
      .cfg_refresh      (cfg_refresh),
      .fifo_level       (fifo_level),
      .pause_req        (pause_req),
      .pause_ack        (pause_ack),
      .pause_class_en   (pause_class_en),
      .pause_class_xoff (pause_class_xoff),
      .pause_quanta     (pause_quanta),
      .xoff_state       (xoff_state),
      .frames_sent      (frames_sent)
   );

   always #5 tx_mac_aclk = ~tx_mac_aclk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_level(input int ch, input logic [LEVEL_W-1:0] val);
      fifo_level[ch*LEVEL_W +: LEVEL_W] = val;
   endtask

   // Bounded wait for pause_req; lat = negedges elapsed.
   task automatic wait_req(input string tag, input int max);
      lat = 0;
      while (pause_req !== 1'b1 && lat < max) begin
         @(negedge tx_mac_aclk);
         lat++;
      end
      check_val({tag, "_req"}, {31'd0, pause_req}, 32'd1);
   endtask

   task automatic do_ack(input string tag);
      pause_ack = 1'b1;
      @(negedge tx_mac_aclk);
      pause_ack = 1'b0;
      exp_frames++;
      check_val({tag, "_req_drop"}, {31'd0, pause_req}, 32'd0);
      check_val({tag, "_frames"}, frames_sent, exp_frames);
   endtask

   task automatic count_req(input int n);
      extra = 0;
      repeat (n) begin
         @(negedge tx_mac_aclk);
         if (pause_req) extra++;
      end
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_mac_resetn = 1'b0;
      cfg_enable    = 1'b1;
      cfg_high      = 4'd8;
      cfg_low       = 4'd4;
      cfg_quanta    = 16'hFFFF;
      cfg_refresh   = '0;
      fifo_level    = '0;
      pause_ack     = 1'b0;
      repeat (3) @(negedge tx_mac_aclk);
      check_val("rst_req",     {31'd0, pause_req}, 32'd0);
      check_val("rst_en",      {24'd0, pause_class_en}, 32'd0);
      check_val("rst_xoff",    {24'd0, pause_class_xoff}, 32'd0);
      check_val("rst_quanta",  {16'd0, pause_quanta}, 32'd0);
      check_val("rst_state",   {24'd0, xoff_state}, 32'd0);
      check_val("rst_frames",  frames_sent, 32'd0);
      tx_mac_resetn = 1'b1;
      repeat (2) @(negedge tx_mac_aclk);

      // Class 2 crosses high: request two cycles later.
      set_level(2, 4'd9);
      @(negedge tx_mac_aclk);
      check_val("t1_req_early", {31'd0, pause_req}, 32'd0);
      check_val("t1_state",     {24'd0, xoff_state}, 32'h04);
      @(negedge tx_mac_aclk);
      check_val("t1_req",    {31'd0, pause_req}, 32'd1);
      check_val("t1_en",     {24'd0, pause_class_en}, 32'h04);
      check_val("t1_xoff",   {24'd0, pause_class_xoff}, 32'h04);
      check_val("t1_quanta", {16'd0, pause_quanta}, 32'hFFFF);
      repeat (3) @(negedge tx_mac_aclk);
      check_val("t1_req_held", {31'd0, pause_req}, 32'd1);
      do_ack("t1");

      // Ack while idle is ignored.
      pause_ack = 1'b1;
      @(negedge tx_mac_aclk);
      pause_ack = 1'b0;
      repeat (2) @(negedge tx_mac_aclk);
      check_val("idle_ack_frames", frames_sent, exp_frames);
      check_val("idle_ack_req",    {31'd0, pause_req}, 32'd0);

      // Hysteresis band: 8 (== high) and 6 hold XOFF; 4 (== low) releases.
      set_level(2, 4'd8);
      repeat (2) @(negedge tx_mac_aclk);
      set_level(2, 4'd6);
      count_req(5);
      check_val("t2_band_noreq", extra, 32'd0);
      check_val("t2_band_state", {24'd0, xoff_state}, 32'h04);
      set_level(2, 4'd4);
      wait_req("t2", 10);
      check_val("t2_lat",  lat, 32'd2);
      check_val("t2_en",   {24'd0, pause_class_en}, 32'h04);
      check_val("t2_xoff", {24'd0, pause_class_xoff}, 32'h00);
      do_ack("t2");

      // Transitions during WAIT are carried in the following frame.
      set_level(2, 4'd9);
      wait_req("t3a", 10);
      do_ack("t3a");
      set_level(2, 4'd0);
      wait_req("t3b", 10);
      check_val("t3b_xoff", {24'd0, pause_class_xoff}, 32'h00);
      set_level(0, 4'd9);
      set_level(5, 4'd9);
      repeat (20) @(negedge tx_mac_aclk);
      check_val("t3_frozen_req",  {31'd0, pause_req}, 32'd1);
      check_val("t3_frozen_en",   {24'd0, pause_class_en}, 32'h04);
      check_val("t3_frozen_xoff", {24'd0, pause_class_xoff}, 32'h00);
      check_val("t3_state",       {24'd0, xoff_state}, 32'h21);
      do_ack("t3b");
      wait_req("t3c", 10);
      check_val("t3c_lat",  lat, 32'd1);
      check_val("t3c_en",   {24'd0, pause_class_en}, 32'h21);
      check_val("t3c_xoff", {24'd0, pause_class_xoff}, 32'h21);
      do_ack("t3c");
      set_level(0, 4'd0);
      set_level(5, 4'd0);
      wait_req("t3d", 10);
      check_val("t3d_en",   {24'd0, pause_class_en}, 32'h21);
      check_val("t3d_xoff", {24'd0, pause_class_xoff}, 32'h00);
      do_ack("t3d");

      // Refresh of a held XOFF class roughly every cfg_refresh cycles.
      cfg_refresh = 24'd100;
      set_level(3, 4'd9);
      wait_req("t4", 10);
      check_val("t4_en",   {24'd0, pause_class_en}, 32'h08);
      check_val("t4_xoff", {24'd0, pause_class_xoff}, 32'h08);
      do_ack("t4");
      for (int k = 0; k < 2; k++) begin
         wait_req("t4_refresh", 150);
         check_val("t4_refresh_period", {31'd0, (lat >= 100 && lat <= 106)}, 32'd1);
         check_val("t4_refresh_en",     {24'd0, pause_class_en}, 32'h08);
         check_val("t4_refresh_xoff",   {24'd0, pause_class_xoff}, 32'h08);
         do_ack("t4_refresh");
      end
      set_level(3, 4'd0);
      wait_req("t4_rel", 10);
      check_val("t4_rel_en",   {24'd0, pause_class_en}, 32'h08);
      check_val("t4_rel_xoff", {24'd0, pause_class_xoff}, 32'h00);
      do_ack("t4_rel");
      count_req(300);
      check_val("t4_quiet", extra, 32'd0);
      cfg_refresh = '0;

      // Global disable releases XOFF classes and blocks new XOFF.
      set_level(1, 4'd9);
      wait_req("t5", 10);
      check_val("t5_en",   {24'd0, pause_class_en}, 32'h02);
      check_val("t5_xoff", {24'd0, pause_class_xoff}, 32'h02);
      do_ack("t5");
      cfg_enable = 1'b0;
      wait_req("t5_dis", 10);
      check_val("t5_dis_lat",   lat, 32'd2);
      check_val("t5_dis_en",    {24'd0, pause_class_en}, 32'h02);
      check_val("t5_dis_xoff",  {24'd0, pause_class_xoff}, 32'h00);
      check_val("t5_dis_state", {24'd0, xoff_state}, 32'h00);
      do_ack("t5_dis");
      count_req(10);
      check_val("t5_dis_quiet", extra, 32'd0);
      check_val("t5_dis_state2", {24'd0, xoff_state}, 32'h00);
      set_level(1, 4'd0);
      cfg_enable = 1'b1;
      repeat (3) @(negedge tx_mac_aclk);

      // Asynchronous reset while waiting for ack.
      set_level(2, 4'd9);
      wait_req("t6", 10);
      #2;
      tx_mac_resetn = 1'b0;
      #1;
      check_val("t6_req",    {31'd0, pause_req}, 32'd0);
      check_val("t6_en",     {24'd0, pause_class_en}, 32'd0);
      check_val("t6_quanta", {16'd0, pause_quanta}, 32'd0);
      check_val("t6_state",  {24'd0, xoff_state}, 32'd0);
      check_val("t6_frames", frames_sent, 32'd0);
      exp_frames = 0;
      fifo_level = '0;
      @(negedge tx_mac_aclk);
      tx_mac_resetn = 1'b1;
      count_req(10);
      check_val("t6_quiet", extra, 32'd0);
      check_val("t6_state_after", {24'd0, xoff_state}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
